// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared scan-code constants and state encodings for the PS/2 key decoder
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;

  // Bytes following E1 in the Pause sequence that carry no key information
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_POP,
    FETCH_SETTLE
  } fetch_state_t;

  typedef enum logic [2:0] {
    DEC_BASE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK,
    DEC_PAUSE
  } dec_state_t;

endpackage

// File: rtl/ps2_fifo_reader.sv
// rtl/ps2_fifo_reader.sv - pops one byte at a time from a first-word fall-through FIFO
module ps2_fifo_reader
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_fifo_empty,
  input  logic [7:0] i_fifo_data,
  output logic       o_fifo_rd,
  output logic [7:0] o_byte,
  output logic       o_byte_strobe
);

  fetch_state_t r_state;
  logic         r_rd;
  logic         r_strobe;
  logic [7:0]   r_byte;

  // SETTLE gives the FIFO a cycle to update its empty flag after the pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= FETCH_IDLE;
      r_rd     <= 1'b0;
      r_strobe <= 1'b0;
      r_byte   <= 8'h00;
    end else begin
      r_rd     <= 1'b0;
      r_strobe <= 1'b0;
      case (r_state)
        FETCH_IDLE: begin
          if (!i_fifo_empty) begin
            r_state  <= FETCH_POP;
            r_rd     <= 1'b1;
            r_strobe <= 1'b1;
            r_byte   <= i_fifo_data;
          end
        end
        FETCH_POP:    r_state <= FETCH_SETTLE;
        FETCH_SETTLE: r_state <= FETCH_IDLE;
        default:      r_state <= FETCH_IDLE;
      endcase
    end
  end

  assign o_fifo_rd     = r_rd;
  assign o_byte        = r_byte;
  assign o_byte_strobe = r_strobe;

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - turns PS/2 set-2 scan bytes into make/break key events
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int REPEAT_FILTER  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic [7:0] w_byte;
  logic       w_strobe;

  ps2_fifo_reader u_reader (
    .clk           (clk),
    .rst           (rst),
    .i_fifo_empty  (fifo_empty),
    .i_fifo_data   (fifo_data),
    .o_fifo_rd     (fifo_rd),
    .o_byte        (w_byte),
    .o_byte_strobe (w_strobe)
  );

  dec_state_t    r_state;
  logic [2:0]    r_skip;
  logic [TW-1:0] r_tmo;
  logic [8:0]    r_held;
  logic          r_held_vld;
  logic [7:0]    r_code;
  logic          r_ext;
  logic          r_brk;
  logic          r_valid;

  dec_state_t w_next_state;
  logic [2:0] w_next_skip;
  logic       w_has_key;
  logic       w_key_ext;
  logic       w_key_brk;
  logic       w_match;
  logic       w_suppress;

  always_comb begin
    w_next_state = r_state;
    w_next_skip  = r_skip;
    w_has_key    = 1'b0;
    w_key_ext    = 1'b0;
    w_key_brk    = 1'b0;
    case (r_state)
      DEC_BASE: begin
        if (w_byte == SC_EXT) begin
          w_next_state = DEC_EXT;
        end else if (w_byte == SC_BRK) begin
          w_next_state = DEC_BRK;
        end else if (w_byte == SC_PAUSE) begin
          w_next_state = DEC_PAUSE;
          w_next_skip  = PAUSE_SKIP;
        end else if (w_byte != SC_BAT_OK && w_byte != SC_ACK) begin
          w_has_key = 1'b1;
        end
      end
      DEC_EXT: begin
        if (w_byte == SC_BRK) begin
          w_next_state = DEC_EXT_BRK;
        end else if (w_byte != SC_EXT) begin
          w_has_key    = 1'b1;
          w_key_ext    = 1'b1;
          w_next_state = DEC_BASE;
        end
      end
      DEC_BRK: begin
        w_has_key    = 1'b1;
        w_key_brk    = 1'b1;
        w_next_state = DEC_BASE;
      end
      DEC_EXT_BRK: begin
        w_has_key    = 1'b1;
        w_key_ext    = 1'b1;
        w_key_brk    = 1'b1;
        w_next_state = DEC_BASE;
      end
      DEC_PAUSE: begin
        if (r_skip <= 3'd1) begin
          w_next_skip  = 3'd0;
          w_next_state = DEC_BASE;
        end else begin
          w_next_skip = r_skip - 3'd1;
        end
      end
      default: w_next_state = DEC_BASE;
    endcase
  end

  assign w_match    = r_held_vld && (r_held == {w_key_ext, w_byte});
  assign w_suppress = (REPEAT_FILTER != 0) && !w_key_brk && w_match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= DEC_BASE;
      r_skip     <= 3'd0;
      r_tmo      <= '0;
      r_held     <= 9'h000;
      r_held_vld <= 1'b0;
      r_code     <= 8'h00;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_strobe) begin
        r_state <= w_next_state;
        r_skip  <= w_next_skip;
        r_tmo   <= '0;
        if (w_has_key) begin
          if (!w_suppress) begin
            r_code  <= w_byte;
            r_ext   <= w_key_ext;
            r_brk   <= w_key_brk;
            r_valid <= 1'b1;
          end
          if (!w_key_brk) begin
            r_held     <= {w_key_ext, w_byte};
            r_held_vld <= 1'b1;
          end else if (w_match) begin
            r_held_vld <= 1'b0;
          end
        end
      end else if (r_state != DEC_BASE) begin
        // A stalled prefix is abandoned silently; the counter never wraps
        if (r_tmo == TMAX) begin
          r_state <= DEC_BASE;
          r_skip  <= 3'd0;
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
      end else begin
        r_tmo <= '0;
      end
    end
  end

  assign key_code  = r_code;
  assign key_ext   = r_ext;
  assign key_break = r_brk;
  assign key_valid = r_valid;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - scoreboard bench for ps2_key_decoder with a FIFO model
module tb_ps2_key_decoder;

  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES (TMO),
    .REPEAT_FILTER  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_break  (key_break),
    .key_valid  (key_valid)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         t_present = 0;
  bit         lat_arm = 1'b0;
  bit         prev_rd = 1'b0;
  bit         was_empty;
  logic [7:0] fq[$];
  logic [9:0] exp_q[$];
  int         rd_times[$];
  logic [9:0] e;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    fq.push_back(b);
  endtask

  task automatic expect_key(input logic [7:0] code, input logic ext, input logic brk);
    exp_q.push_back({ext, brk, code});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (12) @(posedge clk);
    check_eq({tag, "_pending_keys"}, exp_q.size(), 0);
    check_eq({tag, "_pending_bytes"}, fq.size(), 0);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq({tag, "_code"}, key_code, 8'h00);
    check_eq({tag, "_valid"}, key_valid, 0);
    check_eq({tag, "_ext"}, key_ext, 0);
    check_eq({tag, "_brk"}, key_break, 0);
    check_eq({tag, "_rd"}, fifo_rd, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model and output monitor, both on the falling edge
  always @(negedge clk) begin
    if (fifo_rd) begin
      check_eq("rd_nonempty", fifo_empty, 0);
      check_eq("rd_not_back_to_back", prev_rd, 0);
      rd_times.push_back(cyc);
      if (fq.size() > 0) void'(fq.pop_front());
    end
    prev_rd = fifo_rd;
    if (key_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_key_queue_size", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_eq("key_event", {22'd0, key_ext, key_break, key_code}, {22'd0, e});
      end
      if (lat_arm) begin
        check_eq("latency", cyc - t_present, 2);
        lat_arm = 1'b0;
      end
    end
    was_empty  = fifo_empty;
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() == 0) ? 8'h00 : fq[0];
    if (was_empty && !fifo_empty) t_present = cyc;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_code", key_code, 8'h00);
    check_eq("reset_valid", key_valid, 0);
    check_eq("reset_ext", key_ext, 0);
    check_eq("reset_brk", key_break, 0);
    check_eq("reset_rd", fifo_rd, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    lat_arm = 1'b1;
    expect_key(8'h1C, 0, 0);
    expect_key(8'h1C, 0, 1);
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain("make_break");
    check_eq("latency_consumed", lat_arm, 0);

    expect_key(8'h75, 1, 0);
    expect_key(8'h75, 1, 1);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    drain("extended");

    expect_key(8'h1D, 0, 0);
    expect_key(8'h1D, 0, 1);
    expect_key(8'h1D, 0, 0);
    send(8'h1D); send(8'h1D); send(8'h1D); send(8'hF0); send(8'h1D); send(8'h1D);
    drain("repeat_filter");

    expect_key(8'h29, 0, 0);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); send(8'h29);
    drain("pause");
    send(8'hAA); send(8'hFA);
    drain("bat_ack");

    pulse_reset("async_reset");
    send(8'hE0);
    drain("timeout_prefix");
    repeat (TMO + 30) @(posedge clk);
    expect_key(8'h29, 0, 0);
    send(8'h29);
    drain("timeout");

    send(8'hE0);
    drain("reset_prefix");
    pulse_reset("mid_seq_reset");
    expect_key(8'h29, 0, 0);
    send(8'h29);
    drain("after_reset");

    rd_times.delete();
    for (int i = 1; i <= 6; i++) begin
      expect_key(8'(i), 0, 0);
      send(8'(i));
    end
    drain("burst");
    check_eq("burst_pop_count", rd_times.size(), 6);
    for (int i = 1; i < rd_times.size(); i++)
      check_eq("burst_pop_spacing", rd_times[i] - rd_times[i-1], 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2500000, cycles without a byte before an incomplete prefix sequence is abandoned (100 ms at 25 MHz).
REQ-002 SHALL have parameter REPEAT_FILTER, default 1, which when 1 suppresses typematic repeats of the held make code.
REQ-003 SHALL have port clk  input  1  system clock (25 MHz); the block uses one clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port fifo_empty  input  1  PS/2 receive FIFO empty flag (status bit 0).
REQ-006 SHALL have port fifo_data  input  8  FIFO head byte, valid while fifo_empty=0 (first-word fall-through).
REQ-007 SHALL have port fifo_rd  output  1  one-cycle pop strobe to the FIFO.
REQ-008 SHALL have port key_code  output  8  scan code of the decoded event (prefixes stripped).
REQ-009 SHALL have port key_ext  output  1  event carried an E0 prefix.
REQ-010 SHALL have port key_break  output  1  event is a release (F0 seen).
REQ-011 SHALL have port key_valid  output  1  one-cycle strobe qualifying key_code/key_ext/key_break.

Function
REQ-012 Fetch FSM SHALL cycle IDLE -> POP -> SETTLE -> IDLE: IDLE waits for fifo_empty=0; POP captures fifo_data and asserts fifo_rd for exactly one cycle; SETTLE idles one cycle so fifo_empty can update.
REQ-013 fifo_rd SHALL never be asserted while fifo_empty=1 and never on two consecutive cycles.
REQ-014 Decode FSM SHALL have states BASE, EXT, BRK, EXT_BRK, PAUSE and advance only on a byte captured in POP.
REQ-015 BASE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip count 7; AA or FA -> dropped, stay BASE; other byte -> emit make (ext=0), stay BASE.
REQ-016 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> emit make (ext=1), -> BASE.
REQ-017 BRK: any byte -> emit break (ext=0), -> BASE; EXT_BRK: any byte -> emit break (ext=1), -> BASE.
REQ-018 PAUSE: decrement skip count per byte, no emission; return to BASE on the byte that takes the count from 1 to 0 (the 7th byte after E1).
REQ-019 An emission SHALL drive key_code/key_ext/key_break and pulse key_valid high for one cycle, on the cycle after POP; outputs SHALL hold their values until the next emission.
REQ-020 Latency: FIFO byte present in IDLE -> key_valid SHALL be exactly 2 cycles.
REQ-021 With REPEAT_FILTER=1 a make whose {ext,code} equals the held key SHALL not emit; any make SHALL set the held key; a break matching the held key SHALL clear it; a non-matching break SHALL leave it unchanged.
REQ-022 The timeout counter SHALL reset on every POP and count while the decode state is not BASE; on reaching TIMEOUT_CYCLES it SHALL force BASE with no emission.
REQ-023 The timeout counter SHALL saturate, not wrap, and be wide enough for TIMEOUT_CYCLES.
REQ-024 Back-to-back FIFO bytes SHALL be consumed at one byte per 3 cycles, with none lost or duplicated.

Reset
REQ-025 On rst=1, regardless of clk and mid-sequence, the block SHALL set fetch FSM=IDLE, decode FSM=BASE, skip count=0, timeout=0, held key cleared, fifo_rd=0, key_valid=0, key_code=8'h00, key_ext=0, key_break=0.
REQ-026 After rst deasserts, the first byte SHALL be decoded as if no prior prefix was seen.

Structure
REQ-027 Package ps2_pkg SHALL hold constants for E0, F0, E1, AA and FA and the fetch and decode state encodings.
REQ-028 The fetch FSM SHALL be a sub-module ps2_fifo_reader (outputs byte + byte_strobe); decode, filter and timeout logic stay in ps2_key_decoder.

Verification
REQ-029 FIFO bytes 1C, F0, 1C -> make {code=1C, ext=0, brk=0}, then break {code=1C, ext=0, brk=1}; two key_valid pulses.
REQ-030 Bytes E0, 75, E0, F0, 75 -> make {75, ext=1}, then break {75, ext=1, brk=1}.
REQ-031 REPEAT_FILTER=1, bytes 1D, 1D, 1D, F0, 1D, 1D -> emissions: make 1D, break 1D, make 1D (exactly 3).
REQ-032 Bytes E1 14 77 E1 F0 14 F0 77 then 29 -> only make 29 emitted; AA and FA alone -> no emission.
REQ-033 Byte E0, then idle TIMEOUT_CYCLES (bench overrides to 100), then 29 -> make {29, ext=0}; same test with rst pulsed after E0 -> same result.
REQ-034 FIFO preloaded with 6 bytes -> fifo_rd pulses exactly 6 times, 3 cycles apart, never while fifo_empty=1.
